// File: rtl/vga_draw_engine_if.sv
// Command and shared-bus signal bundle for the VGA draw engine.
// The master side is the engine; the slave side is the CPU/bus arbiter environment.
interface vga_draw_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x0;
  logic [7:0] cmd_x1;
  logic [6:0] cmd_y0;
  logic [6:0] cmd_y1;
  logic       cmd_pix;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] bus_addr;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic       bus_we;

  modport master (
    input  cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_pix, bus_gnt,
    output cmd_ready, bus_req, bus_addr, bus_data_out, bus_data_oe, bus_we
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_pix, bus_gnt,
    input  cmd_ready, bus_req, bus_addr, bus_data_out, bus_data_oe, bus_we
  );
endinterface

// File: rtl/vga_draw_engine.sv
// Pixel/rectangle draw engine: queues draw commands and replays each pixel as
// X/Y/pixel writes to the VGA controller window, skipping Y when it is unchanged.
module vga_draw_engine #(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned XMax      = 159,
  parameter int unsigned YMax      = 119
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vga_draw_engine_if.master bus_io,
  output logic              busy_o,
  output logic              done_o
);
  localparam int unsigned     PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(FifoDepth);
  localparam logic [7:0]      XMaxC   = 8'(XMax);
  localparam logic [6:0]      YMaxC   = 7'(YMax);
  localparam logic [7:0]      AddrX   = 8'hB0;
  localparam logic [7:0]      AddrY   = 8'hB1;
  localparam logic [7:0]      AddrP   = 8'hB2;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
    logic       pix;
  } cmd_t;

  typedef enum logic [2:0] {StIdle, StLoad, StWrX, StWrY, StWrP, StStep} state_e;

  cmd_t            fifo_mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push, pop, full, empty;
  cmd_t            cmd_in;

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [7:0] xl_q, xl_d, xh_q, xh_d, cx_q, cx_d;
  logic [6:0] yl_q, yl_d, yh_q, yh_d, cy_q, cy_d, ly_q, ly_d;
  logic       yv_q, yv_d, done_q, done_d;
  logic       req;
  logic [7:0] addr_sel, data_sel;
  logic [7:0] x0c, x1c;
  logic [6:0] y0c, y1c;

  assign cmd_in = {bus_io.cmd_op, bus_io.cmd_x0, bus_io.cmd_x1,
                   bus_io.cmd_y0, bus_io.cmd_y1, bus_io.cmd_pix};
  assign full   = (count_q == CntFull);
  assign empty  = (count_q == '0);
  assign push   = bus_io.cmd_valid && !full;
  assign pop    = (state_q == StIdle) && !empty;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      count_q <= count_q + CntOne;
      else if (pop && !push) count_q <= count_q - CntOne;
    end
  end

  assign x0c = (cmd_q.x0 > XMaxC) ? XMaxC : cmd_q.x0;
  assign x1c = (cmd_q.x1 > XMaxC) ? XMaxC : cmd_q.x1;
  assign y0c = (cmd_q.y0 > YMaxC) ? YMaxC : cmd_q.y0;
  assign y1c = (cmd_q.y1 > YMaxC) ? YMaxC : cmd_q.y1;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    xl_d     = xl_q;
    xh_d     = xh_q;
    cx_d     = cx_q;
    yl_d     = yl_q;
    yh_d     = yh_q;
    cy_d     = cy_q;
    ly_d     = ly_q;
    yv_d     = yv_q;
    done_d   = 1'b0;
    req      = 1'b0;
    addr_sel = '0;
    data_sel = '0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          cmd_d = fifo_mem_q[rd_ptr_q];
          // Reserved op is consumed here and never reaches the bus.
          state_d = (fifo_mem_q[rd_ptr_q].op == 2'd3) ? StIdle : StLoad;
        end
      end
      StLoad: begin
        case (cmd_q.op)
          2'd0: begin
            xl_d = x0c;
            xh_d = x0c;
            yl_d = y0c;
            yh_d = y0c;
          end
          2'd1: begin
            xl_d = (x0c < x1c) ? x0c : x1c;
            xh_d = (x0c < x1c) ? x1c : x0c;
            yl_d = (y0c < y1c) ? y0c : y1c;
            yh_d = (y0c < y1c) ? y1c : y0c;
          end
          default: begin
            xl_d = '0;
            xh_d = XMaxC;
            yl_d = '0;
            yh_d = YMaxC;
          end
        endcase
        cx_d    = xl_d;
        cy_d    = yl_d;
        state_d = StWrX;
      end
      StWrX: begin
        req      = 1'b1;
        addr_sel = AddrX;
        data_sel = cx_q;
        if (bus_io.bus_gnt) state_d = (!yv_q || cy_q != ly_q) ? StWrY : StWrP;
      end
      StWrY: begin
        req      = 1'b1;
        addr_sel = AddrY;
        data_sel = {1'b0, cy_q};
        if (bus_io.bus_gnt) begin
          ly_d    = cy_q;
          yv_d    = 1'b1;
          state_d = StWrP;
        end
      end
      StWrP: begin
        req      = 1'b1;
        addr_sel = AddrP;
        data_sel = {7'b0, cmd_q.pix};
        if (bus_io.bus_gnt) state_d = StStep;
      end
      StStep: begin
        if (cx_q < xh_q) begin
          cx_d    = cx_q + 8'd1;
          state_d = StWrX;
        end else if (cy_q < yh_q) begin
          cx_d    = xl_q;
          cy_d    = cy_q + 7'd1;
          state_d = StWrX;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      xl_q    <= '0;
      xh_q    <= '0;
      cx_q    <= '0;
      yl_q    <= '0;
      yh_q    <= '0;
      cy_q    <= '0;
      ly_q    <= '0;
      yv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      xl_q    <= xl_d;
      xh_q    <= xh_d;
      cx_q    <= cx_d;
      yl_q    <= yl_d;
      yh_q    <= yh_d;
      cy_q    <= cy_d;
      ly_q    <= ly_d;
      yv_q    <= yv_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.cmd_ready    = !full;
  assign bus_io.bus_req      = req;
  assign bus_io.bus_we       = req && bus_io.bus_gnt;
  assign bus_io.bus_data_oe  = bus_io.bus_we;
  assign bus_io.bus_addr     = bus_io.bus_we ? addr_sel : 8'h00;
  assign bus_io.bus_data_out = bus_io.bus_we ? data_sel : 8'h00;
  assign busy_o              = !empty || (state_q != StIdle);
  assign done_o              = done_q;
endmodule
